// File: rtl/fib_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fib_checker                                                |
// | Description : Receive-side checker for an 8-bit modulo-256 Fibonacci     |
// |               sample stream. Seeds from two strobed samples, locks after |
// |               LOCK_MATCHES consecutive correct predictions, then flags   |
// |               data mismatches and strobe timeouts as errors.             |
// | Ports       : clk         - clock                                        |
// |               reset       - synchronous, active-high reset               |
// |               in_valid    - one-cycle strobe qualifying in_data          |
// |               in_data     - 8-bit sample                                 |
// |               locked      - checker is locked to the sequence            |
// |               err         - one-cycle pulse per detected error           |
// |               err_count   - saturating error count                       |
// |               match_count - saturating count of matches while locked     |
// |               expected    - predicted next sample (a+b mod 256)          |
// | Option      : FIB_CHECK_RESYNC_EN - when defined, errors in LOCKED       |
// |               resynchronise instead of latching into FAULT.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fib_checker #(
  parameter int unsigned LOCK_MATCHES = 4,
  parameter logic [19:0] TIMEOUT      = 20'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count,
  output logic [15:0] match_count,
  output logic [7:0]  expected
);

  localparam logic [8:0] c_lock_matches = 9'(LOCK_MATCHES);

  typedef enum logic [2:0] {
    HUNT0  = 3'd0,
    HUNT1  = 3'd1,
    TRACK  = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t      r_state,       w_state_nxt;
  logic [7:0]  r_a,           w_a_nxt;
  logic [7:0]  r_b,           w_b_nxt;
  logic [7:0]  r_run,         w_run_nxt;
  logic [19:0] r_gap,         w_gap_nxt;
  logic        r_locked,      w_locked_nxt;
  logic        r_err,         w_err_nxt;
  logic [15:0] r_err_count,   w_err_count_nxt;
  logic [15:0] r_match_count, w_match_count_nxt;
  logic [7:0]  r_expected,    w_expected_nxt;

  logic        w_match;
  logic [8:0]  w_run_inc;
  logic [19:0] w_gap_inc;
  logic [15:0] w_err_inc;
  logic [15:0] w_match_inc;

  // Prediction uses the natural 8-bit wrap of the sum.
  assign w_match     = (in_data == 8'(r_a + r_b));
  assign w_run_inc   = {1'b0, r_run} + 9'd1;
  assign w_gap_inc   = (r_gap == 20'hFFFFF) ? r_gap : r_gap + 20'd1;
  assign w_err_inc   = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;
  assign w_match_inc = (r_match_count == 16'hFFFF) ? r_match_count : r_match_count + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= HUNT0;
      r_a           <= 8'd0;
      r_b           <= 8'd0;
      r_run         <= 8'd0;
      r_gap         <= 20'd0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_err_count   <= 16'd0;
      r_match_count <= 16'd0;
      r_expected    <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_a           <= w_a_nxt;
      r_b           <= w_b_nxt;
      r_run         <= w_run_nxt;
      r_gap         <= w_gap_nxt;
      r_locked      <= w_locked_nxt;
      r_err         <= w_err_nxt;
      r_err_count   <= w_err_count_nxt;
      r_match_count <= w_match_count_nxt;
      r_expected    <= w_expected_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_a_nxt           = r_a;
    w_b_nxt           = r_b;
    w_run_nxt         = r_run;
    w_locked_nxt      = r_locked;
    w_err_nxt         = 1'b0;
    w_err_count_nxt   = r_err_count;
    w_match_count_nxt = r_match_count;
    // gap only runs while tracking or locked; any strobe clears it.
    if (in_valid)
      w_gap_nxt = 20'd0;
    else if (r_state == TRACK || r_state == LOCKED)
      w_gap_nxt = w_gap_inc;
    else
      w_gap_nxt = 20'd0;

    case (r_state)
      HUNT0: begin
        if (in_valid) begin
          w_a_nxt     = in_data;
          w_state_nxt = HUNT1;
        end
      end
      HUNT1: begin
        if (in_valid) begin
          w_b_nxt     = in_data;
          w_run_nxt   = 8'd0;
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (in_valid) begin
          // Match and mismatch both shift the window; a mismatch re-seeds.
          w_a_nxt = r_b;
          w_b_nxt = in_data;
          if (w_match) begin
            w_run_nxt = w_run_inc[7:0];
            if (w_run_inc == c_lock_matches) begin
              w_state_nxt  = LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_run_nxt = 8'd0;
          end
        end
      end
      LOCKED: begin
        // A strobe takes priority over a coincident timeout.
        if (in_valid) begin
          if (w_match) begin
            w_a_nxt           = r_b;
            w_b_nxt           = in_data;
            w_match_count_nxt = w_match_inc;
          end else begin
            w_err_nxt       = 1'b1;
            w_err_count_nxt = w_err_inc;
            w_locked_nxt    = 1'b0;
`ifdef FIB_CHECK_RESYNC_EN
            w_a_nxt     = r_b;
            w_b_nxt     = in_data;
            w_run_nxt   = 8'd0;
            w_state_nxt = TRACK;
`else
            w_state_nxt = FAULT;
`endif
          end
        end else if (w_gap_inc == TIMEOUT) begin
          w_err_nxt       = 1'b1;
          w_err_count_nxt = w_err_inc;
          w_locked_nxt    = 1'b0;
          w_gap_nxt       = 20'd0;
`ifdef FIB_CHECK_RESYNC_EN
          w_state_nxt = HUNT0;
`else
          w_state_nxt = FAULT;
`endif
        end
      end
      FAULT: begin
        w_locked_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = HUNT0;
        w_locked_nxt = 1'b0;
      end
    endcase

    // Prediction register tracks the a/b pair it is derived from.
    w_expected_nxt = 8'(w_a_nxt + w_b_nxt);
  end

  assign locked      = r_locked;
  assign err         = r_err;
  assign err_count   = r_err_count;
  assign match_count = r_match_count;
  assign expected    = r_expected;

endmodule
`default_nettype wire
